// File: rtl/gpr2_reg.sv
// General-purpose datapath register: synchronous load on write, OR-bus friendly
// read gating (drives zero when not selected), asynchronous active-low reset.
module gpr2_reg #(
    parameter int unsigned     WIDTH       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write,
    input  logic             read,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Enable is a plain condition so an unknown enable never stores X by itself.
    always_comb begin
        q_d = q_q;
        if (write) begin
            q_d = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    // Per-bit AND gating; the read path comes from the register only, never data_in.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rd_gate
            assign data_out[gi] = q_q[gi] & read;
        end
    endgenerate

endmodule

// File: tb/tb_gpr2_reg.sv
// Randomized + directed self-checking bench for gpr2_reg against a behavioural
// "last word written since reset" model.
module tb_gpr2_reg;

    localparam int unsigned      WIDTH = 24;
    localparam logic [WIDTH-1:0] RV    = 24'h000000;

    logic             clk;
    logic             rst_n;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model: the stored word is the most recent data_in sampled by a write edge
    // since the last reset; reset forces RV immediately.
    logic [WIDTH-1:0] model_q = RV;

    gpr2_reg #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .write    (write),
        .read     (read),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            model_q = RV;
        else if (write === 1'b1)
            model_q = data_in;
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [WIDTH-1:0] d);
        write   = w;
        read    = r;
        data_in = d;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en)
            check("model", data_out, read ? model_q : '0);
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 24'd0);
        cmp_en = 1'b1;
        #1 check("reset_read1", data_out, 24'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 check("post_reset_hold", data_out, 24'd0);
        end

        // Basic write/read
        #1 drive(1'b1, 1'b0, 24'd100);
        @(posedge clk);
        #1 check("write_read0", data_out, 24'd0);
        #1 drive(1'b0, 1'b1, 24'd0);
        #1 check("read_100", data_out, 24'd100);
        repeat (2) begin
            @(posedge clk);
            #1 check("hold_100", data_out, 24'd100);
        end

        // Hold and gating with data_in changing
        #1 drive(1'b1, 1'b0, 24'hABCDEF);
        @(posedge clk);
        #1 drive(1'b0, 1'b1, 24'h123456);
        #1 check("gate_on1", data_out, 24'hABCDEF);
        @(posedge clk);
        #1 read = 1'b0;
        #1 check("gate_off", data_out, 24'd0);
        @(posedge clk);
        #1 read = 1'b1;
        #1 check("gate_on2", data_out, 24'hABCDEF);

        // Simultaneous read/write
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 24'd5);
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 24'd9);
        #1 check("rw_before_edge", data_out, 24'd5);
        @(posedge clk);
        #1 check("rw_after_edge", data_out, 24'd9);
        #1 drive(1'b1, 1'b1, 24'hFFFFFF);
        @(posedge clk);
        #1 write = 1'b0;
        #1 check("all_ones", data_out, 24'hFFFFFF);

        // Async reset mid-operation
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 24'h00FF00);
        @(posedge clk);
        #1 write = 1'b0;
        #1 check("pre_reset", data_out, 24'h00FF00);
        rst_n = 1'b0;
        #1 check("async_reset", data_out, 24'd0);
        drive(1'b1, 1'b1, 24'h777777);
        @(posedge clk);
        #1 check("write_in_reset", data_out, 24'd0);
        rst_n = 1'b1;
        write = 1'b0;
        @(posedge clk);
        #1 check("after_release", data_out, 24'd0);
        write = 1'b1;
        data_in = 24'h3C3C3C;
        @(posedge clk);
        #1 write = 1'b0;
        #1 check("write_after_release", data_out, 24'h3C3C3C);

        // Randomized phase with occasional mid-cycle reset pulses
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2 drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     WIDTH'($urandom));
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                #1 check("rand_async_reset", data_out, 24'd0);
                #3 rst_n = 1'b1;
            end
        end

        @(posedge clk);
        #1 cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr2_reg.md
Name: gpr2_reg

Overview:
- 24-bit general-purpose register for the processor datapath.
- Loads `data_in` on a clock edge when `write` is high.
- Drives its stored value onto `data_out` while `read` is high; drives zero otherwise, so several registers can share an OR-combined bus.
- Sits between the processor's internal data bus and its ALU/bus multiplexer.

Parameters:
- WIDTH, 24, data width in bits of the stored word, `data_in` and `data_out`.
- RESET_VALUE, 0, value loaded into the register on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- write  input  1  write enable; load `data_in` at the next rising `clk`.
- read  input  1  read enable; gates the stored value onto `data_out`.
- data_in  input  WIDTH  word to be stored.
- data_out  output  WIDTH  stored word when `read`=1, else all zeros.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is `clk`, reset port is `rst_n`.
- Storage: one WIDTH-bit register `q`.
- Reset:
  - `rst_n`=0 sets `q` to RESET_VALUE immediately, with no clock needed.
  - Reset has priority over `write`.
  - While `rst_n`=0, `data_out` is RESET_VALUE if `read`=1, else 0.
  - Deassertion takes effect at the first rising `clk` with `rst_n`=1.
- Write:
  - At a rising `clk` with `rst_n`=1 and `write`=1, `q` <= `data_in`.
  - Write latency is 1 cycle: the value is visible in `q` right after that edge.
  - With `write`=0, `q` holds its value indefinitely.
- Read:
  - `data_out` is purely combinational: `read` ? `q` : 0.
  - Zero cycles of latency from `read` or `q` changing.
  - No read side effects.
- Simultaneous `write`=1 and `read`=1:
  - Before the edge, `data_out` shows the old `q`.
  - After the edge, it shows the new `data_in` (write-then-read-through-register; no combinational bypass from `data_in`).
- `read`/`write` X or Z: treated as don't-care in synthesis. No X is ever stored from the enable itself; the enable is evaluated as a plain condition.
- Back-to-back writes on consecutive edges each overwrite `q`; last write wins.
- Reset asserted mid-operation:
  - Any pending write is discarded.
  - `q` becomes RESET_VALUE within the same time step.
- Width: no truncation or extension; `data_in` and `data_out` are exactly WIDTH bits.

Test Plan:
- Reset: `rst_n`=0, `read`=1 -> `data_out`=24'd0. Release `rst_n`, `read`=1, `write`=0 for 3 cycles -> `data_out` stays 0.
- Basic write/read:
  - `write`=1, `read`=0, `data_in`=24'd100 for one edge -> `data_out`=0 while `read`=0.
  - Then `write`=0, `read`=1 -> `data_out`=24'd100, held over following edges.
- Hold and gating:
  - After storing 24'hABCDEF, toggle `read` 1/0/1 with `write`=0 and `data_in` changing (24'h123456) -> `data_out` alternates 24'hABCDEF / 0 / 24'hABCDEF.
  - `q` is unchanged throughout.
- Simultaneous read/write:
  - `q`=24'd5, `read`=1, `write`=1, `data_in`=24'd9 -> `data_out`=5 before the edge, 9 after it.
  - Boundary value: write 24'hFFFFFF -> read back 24'hFFFFFF.
- Async reset mid-operation:
  - `q`=24'h00FF00, `read`=1; pulse `rst_n` low between clock edges -> `data_out`=0 immediately, without a clock edge.
  - A `write`=1 edge during reset does not load; after release, the next write loads normally.
